// File: rtl/exmem_stage_pkg.sv
// Shared pipeline definitions: opcode encodings, instruction field positions
// and the datapath word width used by the EX/MEM and MEM/WB stages.
package pipe_defs;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_LW  = 6'b001110;
  localparam logic [5:0] OP_SW  = 6'b001101;
  localparam logic [5:0] OP_ALU = 6'b000100;
  localparam logic [5:0] OP_NOP = 6'b000000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

endpackage

// File: rtl/exmem_stage_data_mem.sv
// Word-addressed data memory: one synchronous write port and one
// combinational read port, optionally zero-filled at time zero.
module data_mem
  import pipe_defs::*;
#(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (INIT_ZERO) begin : g_zero
      logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end

      assign rdata = mem[raddr];
    end else begin : g_raw
      logic [WORD_W-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end

      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with the data memory: SW commits on the edge that
// leaves MEM, LW reads combinationally at the registered address.
module exmem_stage
  import pipe_defs::*;
#(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] ir_ex,
  input  logic [WORD_W-1:0] alu_res_ex,
  input  logic [WORD_W-1:0] store_data_ex,
  output logic [WORD_W-1:0] ir_mem,
  output logic [WORD_W-1:0] alu_res_mem,
  output logic [WORD_W-1:0] mem_read_mem,
  output logic              mem_err
);

  logic [WORD_W-1:0] store_data_mem;
  logic [WORD_W-1:0] rdata;
  logic [5:0]        opcode;
  logic              is_lw;
  logic              is_sw;
  logic              in_range;
  logic              aligned;
  logic              addr_ok;
  logic              mem_we;

  assign opcode   = ir_mem[OP_HI:OP_LO];
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign in_range = (alu_res_mem[WORD_W-1:ADDR_W+2] == '0);
  assign aligned  = (alu_res_mem[1:0] == 2'b00);
  assign addr_ok  = in_range && aligned;

  // The store uses the MEM-stage registers before they advance, so a LW
  // directly behind it sees the new word one edge later.
  assign mem_we = is_sw && addr_ok && !stall && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_mem         <= '0;
      alu_res_mem    <= '0;
      store_data_mem <= '0;
    end else if (flush) begin
      ir_mem         <= '0;
      alu_res_mem    <= '0;
      store_data_mem <= '0;
    end else if (!stall) begin
      ir_mem         <= ir_ex;
      alu_res_mem    <= alu_res_ex;
      store_data_mem <= store_data_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if ((is_lw || is_sw) && !addr_ok) begin
      mem_err <= 1'b1;
    end
  end

  data_mem #(
    .ADDR_W   (ADDR_W),
    .INIT_ZERO(INIT_ZERO)
  ) u_data_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(alu_res_mem[ADDR_W+1:2]),
    .wdata(store_data_mem),
    .raddr(alu_res_mem[ADDR_W+1:2]),
    .rdata(rdata)
  );

  assign mem_read_mem = addr_ok ? rdata : '0;

endmodule
